// File: rtl/fish_sprite_render_if.sv
// Pixel-stream and sprite-ROM bus between the video timing side and the fish renderer.
// The renderer is the slave: it receives x/y and ROM data and returns the ROM address and the pixel.
interface fish_sprite_render_if;
    logic        video_on;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [3:0]  rom_row;
    logic [4:0]  rom_col;
    logic [11:0] rom_color;
    logic        fish_on;
    logic [11:0] rgb_out;

    modport master (
        output video_on, x, y, rom_color,
        input  rom_row, rom_col, fish_on, rgb_out
    );

    modport slave (
        input  video_on, x, y, rom_color,
        output rom_row, rom_col, fish_on, rgb_out
    );
endinterface

// File: rtl/fish_sprite_render.sv
// Swimming fish sprite: bounces between x=0 and X_MAX with a vertical bob, and renders
// its pixels through an external registered sprite ROM with a two-cycle pixel pipeline.
module fish_sprite_render #(
    parameter logic [9:0]  X_MAX     = 10'd608,
    parameter logic [9:0]  BASE_Y    = 10'd200,
    parameter logic [11:0] KEY_COLOR = 12'h0F0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic                        frame_tick,
    input  logic [2:0]                  speed,
    fish_sprite_render_if.slave         pix,
    output logic [9:0]                  fish_x,
    output logic [9:0]                  fish_y,
    output logic                        dir
);

    typedef enum logic [1:0] {IDLE, SWIM_R, SWIM_L} state_t;

    state_t      state, state_next;
    logic [9:0]  fish_x_next;
    logic [2:0]  bob_cnt, bob_cnt_next;
    logic        bob, bob_next;
    logic        dir_next;
    logic        move;
    logic [10:0] sum_r;

    logic        hit;
    logic        hit_p1;
    logic        fish_on_next;
    logic [4:0]  dx;
    logic [3:0]  dy;
    logic [10:0] x_hi, y_hi;

    always_comb begin
        state_next   = state;
        fish_x_next  = fish_x;
        dir_next     = dir;
        bob_cnt_next = bob_cnt;
        bob_next     = bob;
        move         = 1'b0;
        // 11-bit sum so fish_x + speed near X_MAX can never wrap
        sum_r        = {1'b0, fish_x} + {8'd0, speed};
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:   state_next = dir ? SWIM_L : SWIM_R;
                SWIM_R: if (frame_tick) begin
                    move = 1'b1;
                    if (sum_r >= {1'b0, X_MAX}) begin
                        fish_x_next = X_MAX;
                        state_next  = SWIM_L;
                    end else begin
                        fish_x_next = sum_r[9:0];
                    end
                end
                SWIM_L: if (frame_tick) begin
                    move = 1'b1;
                    if (fish_x <= {7'd0, speed}) begin
                        fish_x_next = '0;
                        state_next  = SWIM_R;
                    end else begin
                        fish_x_next = fish_x - {7'd0, speed};
                    end
                end
                default: state_next = IDLE;
            endcase
        end
        if (move) begin
            bob_cnt_next = bob_cnt + 3'd1;
            if (bob_cnt == 3'd7) bob_next = ~bob;
        end
        // dir tracks the swimming state and simply holds through IDLE
        if (state_next == SWIM_L)      dir_next = 1'b1;
        else if (state_next == SWIM_R) dir_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            dir     <= 1'b0;
            fish_x  <= '0;
            bob     <= 1'b0;
            bob_cnt <= '0;
        end else begin
            state   <= state_next;
            dir     <= dir_next;
            fish_x  <= fish_x_next;
            bob     <= bob_next;
            bob_cnt <= bob_cnt_next;
        end
    end

    assign fish_y = BASE_Y + (bob ? 10'd2 : 10'd0);

    // Stage 0: hit test and ROM address; only the low bits of the offsets matter inside the sprite
    assign x_hi = {1'b0, fish_x} + 11'd31;
    assign y_hi = {1'b0, fish_y} + 11'd15;
    assign hit  = pix.video_on && (state != IDLE) &&
                  (pix.x >= fish_x) && ({1'b0, pix.x} <= x_hi) &&
                  (pix.y >= fish_y) && ({1'b0, pix.y} <= y_hi);
    assign dx   = pix.x[4:0] - fish_x[4:0];
    assign dy   = pix.y[3:0] - fish_y[3:0];
    assign pix.rom_row = dy;
    assign pix.rom_col = dir ? ~dx : dx;

    assign fish_on_next = hit_p1 && (pix.rom_color != KEY_COLOR);

    // Stage 1 holds hit alongside the ROM's address register; stage 2 keys out the transparent colour
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hit_p1      <= 1'b0;
            pix.fish_on <= 1'b0;
            pix.rgb_out <= 12'h000;
        end else begin
            hit_p1      <= hit;
            pix.fish_on <= fish_on_next;
            pix.rgb_out <= fish_on_next ? pix.rom_color : 12'h000;
        end
    end

endmodule

// File: tb/tb_fish_sprite_render.sv
// Bench for fish_sprite_render: behavioural motion model, registered ROM model and a
// pixel scoreboard that compares fish_on/rgb_out two cycles after each x/y sample.
module tb_fish_sprite_render;

    logic       clk = 1'b0;
    logic       reset_n, enable, frame_tick;
    logic [2:0] speed;
    logic [9:0] fish_x, fish_y;
    logic       dir;

    always #5 clk = ~clk;

    fish_sprite_render_if pix();

    fish_sprite_render dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .frame_tick (frame_tick),
        .speed      (speed),
        .pix        (pix),
        .fish_x     (fish_x),
        .fish_y     (fish_y),
        .dir        (dir)
    );

    logic [11:0] rom_mem [0:511];
    always @(posedge clk) pix.rom_color <= rom_mem[{pix.rom_row, pix.rom_col}];

    // Motion reference: st_m 0 = idle, 1 = right, 2 = left
    int st_m, x_m, cnt_m;
    bit bob_m, dir_m;
    always @(posedge clk) begin
        if (reset_n === 1'b0) begin
            st_m <= 0; x_m <= 0; cnt_m <= 0; bob_m <= 0; dir_m <= 0;
        end else if (enable !== 1'b1) begin
            st_m <= 0;
        end else if (st_m == 0) begin
            st_m <= dir_m ? 2 : 1;
        end else if (frame_tick === 1'b1) begin
            if (st_m == 1) begin
                if (x_m + int'(speed) >= 608) begin x_m <= 608; st_m <= 2; dir_m <= 1; end
                else x_m <= x_m + int'(speed);
            end else begin
                if (x_m <= int'(speed)) begin x_m <= 0; st_m <= 1; dir_m <= 0; end
                else x_m <= x_m - int'(speed);
            end
            cnt_m <= (cnt_m + 1) % 8;
            if (cnt_m == 7) bob_m <= !bob_m;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic        on;
        logic [11:0] rgb;
    } exp_t;
    exp_t q[$];

    task automatic pop_check();
        exp_t e;
        e = q.pop_front();
        check("fish_on", {31'd0, pix.fish_on}, {31'd0, e.on});
        check("rgb_out", {20'd0, pix.rgb_out}, {20'd0, e.rgb});
    endtask

    task automatic pix_cycle(input bit vo, input int px, input int py);
        exp_t e;
        bit h;
        int cx, cy, col, ym;
        @(negedge clk);
        if (q.size() == 2) pop_check();
        pix.video_on = vo;
        pix.x = px[9:0];
        pix.y = py[9:0];
        ym  = 200 + (bob_m ? 2 : 0);
        cx  = px - x_m;
        cy  = py - ym;
        h   = vo && st_m != 0 && cx >= 0 && cx <= 31 && cy >= 0 && cy <= 15;
        col = dir_m ? 31 - cx : cx;
        e.on  = 1'b0;
        e.rgb = 12'h000;
        if (h && rom_mem[cy*32 + col] != 12'h0F0) begin
            e.on  = 1'b1;
            e.rgb = rom_mem[cy*32 + col];
        end
        q.push_back(e);
        if (h) begin
            #1;
            check("rom_row", {28'd0, pix.rom_row}, cy);
            check("rom_col", {27'd0, pix.rom_col}, col);
        end
    endtask

    task automatic pix_flush();
        repeat (2) begin
            @(negedge clk);
            pix.video_on = 1'b0;
            if (q.size() > 0) pop_check();
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk); frame_tick = 1'b1;
            @(negedge clk); frame_tick = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; enable = 1'b0; frame_tick = 1'b0; pix.video_on = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        q.delete();
    endtask

    task automatic en_on();
        @(negedge clk); enable = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_pos(input string tag);
        check({tag, "_x"},   {22'd0, fish_x}, x_m);
        check({tag, "_y"},   {22'd0, fish_y}, 200 + (bob_m ? 2 : 0));
        check({tag, "_dir"}, {31'd0, dir},    {31'd0, dir_m});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fx, fy;
        reset_n = 1'b0; enable = 1'b0; frame_tick = 1'b0; speed = 3'd0;
        pix.video_on = 1'b0; pix.x = '0; pix.y = '0;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 32; c++)
                rom_mem[r*32 + c] = {r[3:0], c[4:0], 3'b101};
        repeat (3) @(negedge clk);
        check("rst_fish_on", {31'd0, pix.fish_on}, 0);
        check("rst_rgb",     {20'd0, pix.rgb_out}, 0);
        check("rst_x",       {22'd0, fish_x}, 0);
        check("rst_y",       {22'd0, fish_y}, 200);
        check("rst_dir",     {31'd0, dir}, 0);
        reset_n = 1'b1;

        // 10 ticks at speed 4
        speed = 3'd4;
        en_on();
        tick(10);
        check("run10_x", {22'd0, fish_x}, 40);
        check("run10_dir", {31'd0, dir}, 0);
        check_pos("run10");

        // pixel pipeline swimming right
        fx = x_m; fy = 200 + (bob_m ? 2 : 0);
        rom_mem[3*32 + 5] = 12'hD74;
        rom_mem[3*32 + 6] = 12'h0F0;
        pix_cycle(1, fx + 5,  fy + 3);
        pix_cycle(1, fx + 6,  fy + 3);
        pix_cycle(1, fx + 32, fy + 3);
        pix_cycle(1, fx + 31, fy + 15);
        pix_cycle(1, fx,      fy);
        pix_cycle(1, fx + 5,  fy + 16);
        pix_cycle(0, fx + 5,  fy + 3);
        pix_cycle(1, fx - 1,  fy);
        pix_flush();

        // right-edge bounce
        do_reset();
        speed = 3'd6;
        en_on();
        tick(101);
        check("r606_x", {22'd0, fish_x}, 606);
        speed = 3'd5;
        tick(1);
        check("bounceR_x", {22'd0, fish_x}, 608);
        check("bounceR_dir", {31'd0, dir}, 1);
        tick(1);
        check("left1_x", {22'd0, fish_x}, 603);
        check_pos("left1");

        // pixel pipeline mirrored while swimming left
        fx = x_m; fy = 200 + (bob_m ? 2 : 0);
        rom_mem[3*32 + 26] = 12'hA5C;
        pix_cycle(1, fx + 5,  fy + 3);
        pix_cycle(1, fx + 31, fy);
        pix_cycle(1, fx,      fy + 15);
        pix_flush();

        // pause and resume keeps swimming left
        @(negedge clk); enable = 1'b0;
        repeat (2) @(negedge clk);
        en_on();
        tick(1);
        check("resume_x", {22'd0, fish_x}, 598);
        check("resume_dir", {31'd0, dir}, 1);
        tick(119);
        check("l3_x", {22'd0, fish_x}, 3);
        speed = 3'd7;
        tick(1);
        check("bounceL_x", {22'd0, fish_x}, 0);
        check("bounceL_dir", {31'd0, dir}, 0);

        // tick coinciding with enable falling is ignored, then frozen and hidden
        @(negedge clk); enable = 1'b0; frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        check("dis_tick_x", {22'd0, fish_x}, 0);
        tick(5);
        check("frozen_x", {22'd0, fish_x}, 0);
        check_pos("frozen");
        fy = 200 + (bob_m ? 2 : 0);
        pix_cycle(1, 5, fy + 3);
        pix_flush();
        check("hidden_fish_on", {31'd0, pix.fish_on}, 0);

        // bob period
        do_reset();
        speed = 3'd1;
        en_on();
        tick(8);
        check("bob8_y", {22'd0, fish_y}, 202);
        check("bob8_x", {22'd0, fish_x}, 8);
        tick(8);
        check("bob16_y", {22'd0, fish_y}, 200);
        check_pos("bob16");

        // reset in the middle of a move and of a visible line
        speed = 3'd3;
        tick(5);
        fx = x_m; fy = 200 + (bob_m ? 2 : 0);
        pix_cycle(1, fx + 2, fy + 1);
        pix_cycle(1, fx + 3, fy + 1);
        @(negedge clk);
        reset_n = 1'b0; frame_tick = 1'b1;
        pix.video_on = 1'b1; pix.x = 10'(fx + 4); pix.y = 10'(fy + 1);
        @(negedge clk);
        check("mid_rst_fish_on", {31'd0, pix.fish_on}, 0);
        check("mid_rst_rgb",     {20'd0, pix.rgb_out}, 0);
        check("mid_rst_x",       {22'd0, fish_x}, 0);
        check("mid_rst_y",       {22'd0, fish_y}, 200);
        check("mid_rst_dir",     {31'd0, dir}, 0);
        reset_n = 1'b1; frame_tick = 1'b0; pix.video_on = 1'b0;
        q.delete();
        @(negedge clk);
        check("post_rst_fish_on", {31'd0, pix.fish_on}, 0);
        check("post_rst_rgb",     {20'd0, pix.rgb_out}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
